// File: rtl/bram_transpose_reader.sv
// Reads a ROWS x COLS row-major tile out of a two-cycle-latency memory in column-major order
// and streams it through a credit-protected FIFO on a valid/ready interface.
module bram_transpose_reader #(
   parameter int DATAW      = 8,
   parameter int ROWS       = 4,
   parameter int COLS       = 4,
   parameter int DEPTH      = ROWS*COLS,
   parameter int ADDRW      = $clog2(DEPTH),
   parameter int READ_LAT   = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [ADDRW-1:0] base_addr,
   output logic             busy,
   output logic             done,
   output logic [ADDRW-1:0] mem_raddr,
   input  logic [DATAW-1:0] mem_rdata,
   output logic [DATAW-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last
);
   localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNTW = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;

   state_t                  state_r, state_s;
   logic [RW-1:0]           row_r, row_s;
   logic [CW-1:0]           col_r, col_s;
   logic [ADDRW-1:0]        base_r, raddr_r, raddr_s;
   logic [READ_LAT-1:0]     pipe_valid_r, pipe_last_r, pipe_valid_s, pipe_last_s;
   logic [DATAW-1:0]        fifo_data_r [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0]   fifo_last_r;
   logic [PW-1:0]           wr_ptr_r, rd_ptr_r;
   logic [CNTW-1:0]         count_r, count_s;
   logic                    busy_r, done_r, done_s;
   logic                    issue_s, last_elem_s, push_s, pop_s, accept_s;
   logic [31:0]             addr_sum_s;

   function automatic logic [31:0] count_ones(input logic [READ_LAT-1:0] v);
      logic [31:0] n;
      n = 32'd0;
      for (int i = 0; i < READ_LAT; i++) n = n + {31'd0, v[i]};
      return n;
   endfunction

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (32'(p) == FIFO_DEPTH - 1) ? PW'(0) : p + PW'(1);
   endfunction

   // A read is issued only while queued plus in-flight words leave a free FIFO slot.
   assign issue_s     = (state_r == ISSUE) &&
                        ((32'(count_r) + count_ones(pipe_valid_r)) < 32'(FIFO_DEPTH));
   assign last_elem_s = (32'(row_r) == ROWS - 1) && (32'(col_r) == COLS - 1);
   assign accept_s    = (state_r == IDLE) && start;
   assign push_s      = pipe_valid_r[READ_LAT-1];
   assign pop_s       = out_valid && out_ready;
   assign count_s     = count_r + CNTW'(push_s) - CNTW'(pop_s);
   assign pipe_valid_s = READ_LAT'({pipe_valid_r, issue_s});
   assign pipe_last_s  = READ_LAT'({pipe_last_r, issue_s && last_elem_s});
   assign addr_sum_s   = 32'(base_r) + 32'(row_s) * 32'(COLS) + 32'(col_s);

   // Next-state, counter advance and done detection.
   always_comb begin
      state_s = state_r;
      row_s   = row_r;
      col_s   = col_r;
      done_s  = 1'b0;
      raddr_s = raddr_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_s = ISSUE;
               row_s   = RW'(0);
               col_s   = CW'(0);
               raddr_s = base_addr;
            end else begin
               state_s = IDLE;
            end
         end
         ISSUE: begin
            if (issue_s && last_elem_s) begin
               state_s = DRAIN;
            end else if (issue_s) begin
               if (32'(row_r) == ROWS - 1) begin
                  row_s = RW'(0);
                  col_s = col_r + CW'(1);
               end else begin
                  row_s = row_r + RW'(1);
               end
               raddr_s = addr_sum_s[ADDRW-1:0];
            end else begin
               state_s = ISSUE;
            end
         end
         DRAIN: begin
            // Leave one edge early so done lands in the cycle right after the final pop.
            if ((pipe_valid_s == READ_LAT'(0)) && (count_s == CNTW'(0))) begin
               state_s = IDLE;
               done_s  = 1'b1;
            end else begin
               state_s = DRAIN;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // Control, address and issue-pipe registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         row_r        <= RW'(0);
         col_r        <= CW'(0);
         base_r       <= ADDRW'(0);
         raddr_r      <= ADDRW'(0);
         pipe_valid_r <= READ_LAT'(0);
         pipe_last_r  <= READ_LAT'(0);
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
      end else begin
         state_r      <= state_s;
         row_r        <= row_s;
         col_r        <= col_s;
         base_r       <= accept_s ? base_addr : base_r;
         raddr_r      <= raddr_s;
         pipe_valid_r <= pipe_valid_s;
         pipe_last_r  <= pipe_last_s;
         busy_r       <= (state_s != IDLE);
         done_r       <= done_s;
      end
   end

   // Output FIFO storage and pointers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_data_r[i] <= DATAW'(0);
         fifo_last_r <= FIFO_DEPTH'(0);
         wr_ptr_r    <= PW'(0);
         rd_ptr_r    <= PW'(0);
         count_r     <= CNTW'(0);
      end else begin
         if (push_s) begin
            fifo_data_r[wr_ptr_r] <= mem_rdata;
            fifo_last_r[wr_ptr_r] <= pipe_last_r[READ_LAT-1];
            wr_ptr_r              <= ptr_inc(wr_ptr_r);
         end
         if (pop_s) rd_ptr_r <= ptr_inc(rd_ptr_r);
         count_r <= count_s;
      end
   end

   assign busy      = busy_r;
   assign done      = done_r;
   assign mem_raddr = raddr_r;
   assign out_valid = (count_r != CNTW'(0));
   assign out_data  = fifo_data_r[rd_ptr_r];
   assign out_last  = fifo_last_r[rd_ptr_r];
endmodule

// File: doc/bram_transpose_reader.md
Name: bram_transpose_reader

Overview:
- Read-side controller for a bram_mem-style memory: two-cycle registered read path, with the address registered in and the data registered out.
- Fetches a ROWS x COLS tile stored row-major starting at a base address, in column-major (transposed) order.
- Streams the words out on a valid/ready interface, with a small credit-controlled FIFO that absorbs memory latency under backpressure.
- Sits between the tile memory and the downstream transpose consumer.

Parameters:
- DATAW, 8, word width.
- ROWS, 4, tile rows.
- COLS, 4, tile columns.
- DEPTH, ROWS*COLS, memory depth in words.
- ADDRW, $clog2(DEPTH), address width.
- READ_LAT, 2, cycles from mem_raddr presented to mem_rdata valid.
- FIFO_DEPTH, 4, output FIFO entries; must be >= READ_LAT+1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  ADDRW  tile base; latched on accepted start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the final output handshake.
- mem_raddr  out  ADDRW  read address to memory.
- mem_rdata  in  DATAW  read data from memory.
- out_data  out  DATAW  FIFO head word.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accept.
- out_last  out  1  high with the final tile word.

Behaviour:
- Reset (asynchronous, while rst_n=0) forces:
  - state IDLE; busy=0, done=0.
  - out_valid=0, out_last=0, out_data=0, mem_raddr=0.
  - row/col counters 0; issue pipe cleared; FIFO emptied.
- States: IDLE, ISSUE, DRAIN.
  - IDLE + start: latch base, row=0, col=0 -> ISSUE.
  - ISSUE after the last element (row=ROWS-1, col=COLS-1) is issued -> DRAIN.
  - DRAIN when pipe empty and FIFO empty -> IDLE, with done=1 for exactly one cycle. busy=0 in the same cycle.
  - start outside IDLE is ignored.
- Address generation:
  - mem_raddr = (base + row*COLS + col) mod 2^ADDRW, driven from registered counters. The wrap is natural truncation.
  - Order is column-major: row increments first; at ROWS-1 row wraps to 0 and col increments.
- Issue rule: in ISSUE, an issue occurs in a cycle iff fifo_count + inflight < FIFO_DEPTH.
  - inflight = number of set bits in the READ_LAT-deep issue pipe.
  - A simultaneous pop is not credited, so the rule is conservative.
  - Counters advance only on issue; mem_raddr holds otherwise.
- Issue pipe: each stage carries {valid, last}.
  - When stage READ_LAT-1 is valid, mem_rdata is written into the FIFO on that edge, together with the last tag.
  - Data arriving with no valid pipe bit is discarded.
- FIFO: push and pop in the same cycle are both allowed; count is unchanged. Overflow is impossible by the credit rule.
- Output handshake: transfer on out_valid & out_ready. out_data and out_last are stable while out_valid=1 and out_ready=0.
- Timing with out_ready=1 throughout (ROWS=COLS=4, start sampled in cycle 0):
  - first mem_raddr in cycle 1;
  - first out_valid in cycle 4;
  - one word per cycle, no bubbles;
  - last handshake in cycle 19;
  - done in cycle 20.
- Reset mid-operation: everything clears immediately. Memory reads still in flight are dropped because the pipe is cleared.

Test Plan:
- mem[i]=i, base=0, out_ready=1 -> outputs 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15; out_last only with 15; first out_valid in cycle 4; done one pulse in cycle 20.
- Same preload, out_ready toggling 1,0,0,1 repeating -> identical sequence with no loss or duplication. FIFO count never exceeds 4. mem_raddr stalls whenever count+inflight=4.
- base=12 -> addresses wrap mod 16; outputs 12,0,4,8,13,1,5,9,14,2,6,10,15,3,7,11.
- start pulsed again in cycle 6 of an active tile -> ignored; exactly 16 words and one done.
- rst_n low in cycle 8, released in cycle 10, then a new start -> out_valid=0 during reset; no stale words appear; the new tile emits the full 16 words.
- out_ready=0 for 20 cycles after start -> exactly 4 issues; out_valid=1 with out_data=0 held. Releasing out_ready completes the tile normally.
